uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART_Tx instance between NUM_REQ byte-stream requesters.
- Each requester offers bytes on a valid/ready handshake, with a `last` flag marking the end of a message.
- Once granted, a requester keeps the transmitter until its `last` byte has finished, so messages are never interleaved on the serial line.
- The block sits between the per-source FIFOs and the UART_Tx tx_start/tx_data/tx_busy interface.

---
 rtl/uart_ctrl_pkg.sv | 19 +
 rtl/uart_tx_sched_if.sv | 32 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_sched.sv | 154 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
package uart_ctrl_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } sched_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned ID_W(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester byte streams, UART_Tx launch signals and grant status for uart_tx_sched.
interface uart_tx_sched_if
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IW = ID_W(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [UART_DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_start;
  logic [UART_DATA_W-1:0]         tx_data;
  logic                           tx_busy;
  logic                           grant_valid;
  logic [IW-1:0]                  grant_id;
  logic                           err_timeout;

  // Requester/UART side.
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant_valid, grant_id, err_timeout
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_valid, grant_id, err_timeout
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = ID_W(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_c,
  output logic [IW-1:0]      o_idx_c,
  output logic               o_any_c
);

  logic [IW-1:0] w_cand;

  // Scan from the farthest offset down so the closest request to i_ptr wins.
  always_comb begin
    o_idx_c = '0;
    o_any_c = 1'b0;
    w_cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = IW'((32'(i_ptr) + 32'(unsigned'(k))) % NUM_REQ);
      if (i_req[w_cand]) begin
        o_idx_c = w_cand;
        o_any_c = 1'b1;
      end
    end
  end

  assign o_gnt_c = o_any_c ? (NUM_REQ'(1) << o_idx_c) : '0;

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART_Tx between NUM_REQ byte-stream requesters; a granted
// requester keeps the line until its last byte has been shifted out.
module uart_tx_sched
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input logic            clk,
  input logic            rst,
  uart_tx_sched_if.slave bus
);

  localparam int unsigned IW  = ID_W(NUM_REQ);
  localparam int unsigned BCW = ID_W(BUSY_TIMEOUT);
  localparam int unsigned LCW = ID_W(LOCK_TIMEOUT);

  sched_state_e           r_state;
  logic [IW-1:0]          r_rr_ptr;
  logic [IW-1:0]          r_grant_id;
  logic                   r_grant_valid;
  logic                   r_lock;
  logic                   r_last;
  logic [LCW-1:0]         r_lock_cnt;
  logic [BCW-1:0]         r_busy_cnt;
  logic                   r_tx_start;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic [NUM_REQ-1:0]     r_req_ready;
  logic                   r_err;

  logic [NUM_REQ-1:0]     w_arb_gnt;
  logic [IW-1:0]          w_arb_idx;
  logic                   w_arb_any;
  logic                   w_xfer;
  logic [IW-1:0]          w_ptr_next;
  logic [BCW-1:0]         w_busy_inc;
  logic [LCW-1:0]         w_lock_inc;
  logic [UART_DATA_W-1:0] w_data;
  logic                   w_last;
  logic [NUM_REQ-1:0]     w_owner_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt_c (w_arb_gnt),
    .o_idx_c (w_arb_idx),
    .o_any_c (w_arb_any)
  );

  // Ready is only ever set for the owner, so any overlap is the owner's transfer.
  assign w_xfer     = |(bus.req_valid & r_req_ready);
  assign w_ptr_next = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + IW'(1);
  assign w_busy_inc = r_busy_cnt + BCW'(1);
  assign w_lock_inc = r_lock_cnt + LCW'(1);
  assign w_data     = bus.req_data[UART_DATA_W*r_grant_id +: UART_DATA_W];
  assign w_last     = bus.req_last[r_grant_id];
  assign w_owner_oh = NUM_REQ'(1) << r_grant_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_lock        <= 1'b0;
      r_last        <= 1'b0;
      r_lock_cnt    <= '0;
      r_busy_cnt    <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_req_ready   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_grant_id    <= w_arb_idx;
            r_grant_valid <= 1'b1;
            r_req_ready   <= w_arb_gnt;
            r_state       <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (w_xfer) begin
            r_tx_data   <= w_data;
            r_last      <= w_last;
            r_req_ready <= '0;
            r_tx_start  <= 1'b1;
            r_state     <= LAUNCH;
          end else if (!r_lock) begin
            r_grant_valid <= 1'b0;
            r_req_ready   <= '0;
            r_state       <= IDLE;
          end else if (w_lock_inc == LCW'(LOCK_TIMEOUT - 1)) begin
            // Owner stalled mid-message: revoke so others are not starved.
            r_err         <= 1'b1;
            r_lock        <= 1'b0;
            r_grant_valid <= 1'b0;
            r_req_ready   <= '0;
            r_rr_ptr      <= w_ptr_next;
            r_state       <= IDLE;
          end else begin
            r_lock_cnt <= w_lock_inc;
          end
        end
        LAUNCH: begin
          r_busy_cnt <= '0;
          r_state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (w_busy_inc == BCW'(BUSY_TIMEOUT - 1)) begin
            // UART never acknowledged: drop the byte and the whole grant.
            r_err         <= 1'b1;
            r_lock        <= 1'b0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= w_ptr_next;
            r_state       <= IDLE;
          end else begin
            r_busy_cnt <= w_busy_inc;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (r_last) begin
              r_lock        <= 1'b0;
              r_grant_valid <= 1'b0;
              r_rr_ptr      <= w_ptr_next;
              r_state       <= IDLE;
            end else begin
              r_lock      <= 1'b1;
              r_lock_cnt  <= '0;
              r_req_ready <= w_owner_oh;
              r_state     <= ACCEPT;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_id    = r_grant_id;
  assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: queued requester streams, a UART_Tx busy model,
// expected launches checked by an independent monitor.
module tb_uart_tx_sched;
  import uart_ctrl_pkg::*;

  localparam int unsigned N    = 4;
  localparam int          BLEN = 7;

  localparam int SEL_START   = 0;
  localparam int SEL_ERR     = 1;
  localparam int SEL_BUSY_HI = 2;
  localparam int SEL_BUSY_LO = 3;
  localparam int SEL_GRANT2  = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } launch_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         uart_en = 1'b1;
  logic [N-1:0] xfer_s = '0;
  logic [8:0] src_q [N][$];
  launch_t    exp_q [$];
  logic [7:0] last_d = '0;
  int         u_cnt;
  int         s0, e0, s1, e1, d0, tmp;

  uart_tx_sched_if #(.NUM_REQ(N)) bus ();

  uart_tx_sched #(
    .NUM_REQ      (N),
    .BUSY_TIMEOUT (8),
    .LOCK_TIMEOUT (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input int src, input logic last, input logic [7:0] d);
    src_q[src].push_back({last, d});
  endtask

  task automatic expect_launch(input int id, input logic [7:0] d);
    launch_t e;
    e.id = 2'(id);
    e.d  = d;
    exp_q.push_back(e);
  endtask

  // UART_Tx model: busy rises 2 cycles after tx_start and stays high BLEN-1 cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_cnt       <= 0;
      bus.tx_busy <= 1'b0;
    end else if (u_cnt == 0) begin
      if (bus.tx_start && uart_en) u_cnt <= 1;
    end else if (u_cnt == BLEN) begin
      u_cnt       <= 0;
      bus.tx_busy <= 1'b0;
    end else begin
      u_cnt       <= u_cnt + 1;
      bus.tx_busy <= 1'b1;
    end
  end

  // Requester FIFOs: present queue heads, pop on the handshake seen before the edge.
  always @(negedge clk) xfer_s = bus.req_valid & bus.req_ready;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(N); i++) begin
        if (xfer_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = src_q[i][0][7:0];
          bus.req_last[i]        = src_q[i][0][8];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: every launch must match the next expected (id, byte) and never overlap busy.
  always @(negedge clk) begin
    if (rst && bus.tx_start) begin
      chk("no_overlap", 32'(bus.tx_busy), 32'h0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL launch: actual=id%0d/%0h required=none", bus.grant_id, bus.tx_data);
      end else begin
        launch_t e;
        e = exp_q.pop_front();
        last_d = e.d;
        chk("launch_id", 32'(bus.grant_id), 32'(e.id));
        chk("launch_data", 32'(bus.tx_data), 32'(e.d));
      end
    end
    if (rst && bus.tx_busy) chk("tx_data_hold", 32'(bus.tx_data), 32'(last_d));
  end

  task automatic wait_for(input int sel, input int budget, input string nm, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      case (sel)
        SEL_START:   hit = bus.tx_start;
        SEL_ERR:     hit = bus.err_timeout;
        SEL_BUSY_HI: hit = bus.tx_busy;
        SEL_BUSY_LO: hit = !bus.tx_busy;
        default:     hit = bus.grant_valid && (bus.grant_id == 2'd2);
      endcase
    end
    if (hit) at = cyc;
    else begin
      total++;
      bad++;
      $display("FAIL %s: actual=timeout required=event within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_quiet(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0) &&
           (src_q[3].size() == 0) && (bus.req_valid == '0) && !bus.grant_valid && !bus.tx_busy;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: actual=active required=quiet", nm);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_grant_valid", 32'(bus.grant_valid), 32'h0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
    chk("rst_err", 32'(bus.err_timeout), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fairness from rr_ptr=0: 0,1,2,3 then requester 0 again.
    expect_launch(0, 8'h10); expect_launch(1, 8'h21); expect_launch(2, 8'h32);
    expect_launch(3, 8'h43); expect_launch(0, 8'h10);
    push(0, 1'b1, 8'h10); push(0, 1'b1, 8'h10);
    push(1, 1'b1, 8'h21); push(2, 1'b1, 8'h32); push(3, 1'b1, 8'h43);
    wait_quiet("fair_quiet");
    chk("fair_drained", 32'(exp_q.size()), 32'h0);

    // Single byte with latency: ready at cycle 1, tx_start at cycle 2.
    expect_launch(0, 8'hA5);
    push(0, 1'b1, 8'hA5);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("single_ready_c0", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    chk("single_ready_c1", 32'(bus.req_ready), 32'h1);
    chk("single_gv_c1", 32'(bus.grant_valid), 32'h1);
    @(negedge clk);
    chk("single_start_c2", 32'(bus.tx_start), 32'h1);
    chk("single_data_c2", 32'(bus.tx_data), 32'hA5);
    wait_quiet("single_quiet");
    chk("single_released", 32'(bus.grant_valid), 32'h0);

    // rr_ptr is now 1: requester 1 beats requester 0.
    expect_launch(1, 8'h22); expect_launch(0, 8'h11);
    push(0, 1'b1, 8'h11); push(1, 1'b1, 8'h22);
    wait_quiet("rrptr_quiet");

    // Message lock: requester 2 keeps the line while requester 1 waits.
    expect_launch(2, 8'h01); expect_launch(2, 8'h02); expect_launch(2, 8'h03);
    expect_launch(1, 8'h55);
    push(2, 1'b0, 8'h01); push(2, 1'b0, 8'h02); push(2, 1'b1, 8'h03);
    wait_for(SEL_GRANT2, 50, "lock_grant2", tmp);
    push(1, 1'b1, 8'h55);
    wait_quiet("lock_quiet");

    // Busy timeout: UART never acknowledges.
    uart_en = 1'b0;
    expect_launch(3, 8'h99); expect_launch(0, 8'h66);
    push(3, 1'b1, 8'h99); push(0, 1'b1, 8'h66);
    wait_for(SEL_START, 50, "bto_start0", s0);
    wait_for(SEL_ERR, 50, "bto_err0", e0);
    chk("bto_delay0", 32'(e0 - s0), 32'd8);
    chk("bto_release0", 32'(bus.grant_valid), 32'h0);
    wait_for(SEL_START, 50, "bto_start1", s1);
    wait_for(SEL_ERR, 50, "bto_err1", e1);
    chk("bto_delay1", 32'(e1 - s1), 32'd8);
    uart_en = 1'b1;
    wait_quiet("bto_quiet");

    // Asynchronous reset during WAIT_DONE; rr_ptr=1 beforehand.
    expect_launch(2, 8'h77);
    push(2, 1'b1, 8'h77);
    wait_for(SEL_BUSY_HI, 50, "rst_busy", tmp);
    @(negedge clk);
    chk("pre_rst_gv", 32'(bus.grant_valid), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("mid_rst_tx_data", 32'(bus.tx_data), 32'h0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    chk("mid_rst_gv", 32'(bus.grant_valid), 32'h0);
    chk("mid_rst_gid", 32'(bus.grant_id), 32'h0);
    chk("mid_rst_err", 32'(bus.err_timeout), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_launch(0, 8'h0A); expect_launch(3, 8'h3B);
    push(0, 1'b1, 8'h0A); push(3, 1'b1, 8'h3B);
    wait_quiet("post_rst_quiet");

    // Lock timeout: requester 3 sends a non-last byte then goes silent.
    expect_launch(3, 8'hC3);
    push(3, 1'b0, 8'hC3);
    wait_for(SEL_BUSY_HI, 50, "lto_busy_hi", tmp);
    wait_for(SEL_BUSY_LO, 50, "lto_busy_lo", d0);
    @(negedge clk);
    chk("lto_ready_held", 32'(bus.req_ready), 32'h8);
    chk("lto_gv_held", 32'(bus.grant_valid), 32'h1);
    wait_for(SEL_ERR, 1100, "lto_err", e0);
    chk("lto_delay", 32'(e0 - d0), 32'd1024);
    chk("lto_gv_clear", 32'(bus.grant_valid), 32'h0);
    chk("lto_ready_clear", 32'(bus.req_ready), 32'h0);
    wait_quiet("lto_quiet");

    chk("all_launched", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
